// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm -- multi-cycle main controller for the MIPS datapath.
//
// Steps a state machine through fetch, decode, execute, memory and
// write-back, decoding the datapath strobes combinationally from the
// state register (Moore).  IRWrite/PCWrite in IF depend on mem_ready_i.
// PCWrite in BR depends on zero_i.  The wait-state exits also depend on
// mem_ready_i.
//
// Optional feature: define MC_CTRL_JUMP_EN to route opcode 000010 (j)
// through the JMP state.  Without it, j decodes as an unknown opcode.
//
// Memory handshake: the controller holds MemRead/MemWrite asserted in a
// wait state (IF, MEM_RD, MEM_WR).  The memory raises mem_ready_i in the
// cycle the access completes.  That cycle is the last one spent in the
// wait state.  There is no back-pressure in the other direction.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   instr_op_i[5:0]  opcode from IR, stable from ID until back in IF
//   mem_ready_i      memory completes current access this cycle
//   zero_i           ALU zero flag
//   ALUOp_o[2:0], ALUSrcA_o, ALUSrcB_o[1:0], IorD_o, MemRead_o,
//   MemWrite_o, IRWrite_o, PCWrite_o, RegWrite_o, RegDst_o, MemtoReg_o,
//   PCSrc_o[1:0]     datapath controls
//   state_o[3:0]     current state code (debug/observation)
//   err_o            sticky fault flag (set while in ERR)
module mc_ctrl_fsm #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output logic [2:0] ALUOp_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       PCWrite_o,
  output logic       RegWrite_o,
  output logic       RegDst_o,
  output logic       MemtoReg_o,
  output logic [1:0] PCSrc_o,
  output logic [3:0] state_o,
  output logic       err_o
);

  localparam logic [3:0] S_IF       = 4'd0;
  localparam logic [3:0] S_ID       = 4'd1;
  localparam logic [3:0] S_EX_R     = 4'd2;
  localparam logic [3:0] S_EX_I     = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_MEM   = 4'd7;
  localparam logic [3:0] S_WB_R     = 4'd8;
  localparam logic [3:0] S_WB_I     = 4'd9;
  localparam logic [3:0] S_BR       = 4'd10;
  localparam logic [3:0] S_JMP      = 4'd11;
  localparam logic [3:0] S_RST      = 4'd12;
  localparam logic [3:0] S_ERR      = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_CTRL_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          in_wait;

  // IF, MEM_RD and MEM_WR are the only states that block on memory.
  assign in_wait = (state_q == S_IF) || (state_q == S_MEM_RD) ||
                   (state_q == S_MEM_WR);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST: state_d = S_IF;
      S_IF: begin
        if (mem_ready_i)                  state_d = S_ID;
        else if (wait_cnt_q == CNT_LAST)  state_d = S_ERR;
      end
      S_ID: begin
        case (instr_op_i)
          OP_RTYPE:       state_d = S_EX_R;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_ADDI,
          OP_SLTI:        state_d = S_EX_I;
          OP_BEQ:         state_d = S_BR;
`ifdef MC_CTRL_JUMP_EN
          OP_J:           state_d = S_JMP;
`endif
          default:        state_d = S_IF;
        endcase
      end
      S_EX_R:     state_d = S_WB_R;
      S_WB_R:     state_d = S_IF;
      S_EX_I:     state_d = S_WB_I;
      S_WB_I:     state_d = S_IF;
      S_MEM_ADDR: state_d = (instr_op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready_i)                  state_d = S_WB_MEM;
        else if (wait_cnt_q == CNT_LAST)  state_d = S_ERR;
      end
      S_MEM_WR: begin
        if (mem_ready_i)                  state_d = S_IF;
        else if (wait_cnt_q == CNT_LAST)  state_d = S_ERR;
      end
      S_WB_MEM:   state_d = S_IF;
      S_BR:       state_d = S_IF;
`ifdef MC_CTRL_JUMP_EN
      S_JMP:      state_d = S_IF;
`endif
      S_ERR:      state_d = S_ERR;
      // Unused codes (and JMP when jumps are not built in) are faults.
      default:    state_d = S_ERR;
    endcase
  end

  // Consecutive not-ready counter.  It is cleared whenever the state
  // changes.  It therefore only ever counts within one wait state.  It
  // cannot wrap, because reaching CNT_LAST forces the exit to ERR.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q)             wait_cnt_d = '0;
    else if (in_wait && !mem_ready_i)   wait_cnt_d = wait_cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_RST;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Output decode.
  always_comb begin
    ALUOp_o    = 3'b000;
    ALUSrcA_o  = 1'b0;
    ALUSrcB_o  = 2'b00;
    IorD_o     = 1'b0;
    MemRead_o  = 1'b0;
    MemWrite_o = 1'b0;
    IRWrite_o  = 1'b0;
    PCWrite_o  = 1'b0;
    RegWrite_o = 1'b0;
    RegDst_o   = 1'b0;
    MemtoReg_o = 1'b0;
    PCSrc_o    = 2'b00;
    case (state_q)
      S_IF: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        IRWrite_o = mem_ready_i;
        PCWrite_o = mem_ready_i;
      end
      // Branch target precompute: PC + (imm << 2).
      S_ID: ALUSrcB_o = 2'b11;
      S_EX_R: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = 3'b010;
      end
      S_WB_R: begin
        RegDst_o   = 1'b1;
        RegWrite_o = 1'b1;
      end
      S_EX_I: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        ALUOp_o   = (instr_op_i == OP_SLTI) ? 3'b011 : 3'b000;
      end
      S_WB_I: RegWrite_o = 1'b1;
      S_MEM_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
      end
      S_MEM_RD: begin
        IorD_o    = 1'b1;
        MemRead_o = 1'b1;
      end
      S_MEM_WR: begin
        IorD_o     = 1'b1;
        MemWrite_o = 1'b1;
      end
      S_WB_MEM: begin
        MemtoReg_o = 1'b1;
        RegWrite_o = 1'b1;
      end
      S_BR: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = 3'b001;
        PCSrc_o   = 2'b01;
        PCWrite_o = zero_i;
      end
`ifdef MC_CTRL_JUMP_EN
      S_JMP: begin
        PCSrc_o   = 2'b10;
        PCWrite_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign state_o = state_q;
  assign err_o   = (state_q == S_ERR);

endmodule
